// File: rtl/audio_mixer_tdm.sv
// Time-multiplexed N-channel stereo mixer: snapshot on strobe, serial MAC, shift/saturate.
// Optional first-order delta-sigma DAC outputs when AUDIO_MIXER_DSM_EN is defined.
module audio_mixer_tdm #(
  parameter int CH_NUM = 8,
  parameter int IN_W   = 16,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 16
) (
  input  logic                       clk21m,
  input  logic                       reset,
  input  logic                       smp_strobe,
  input  logic [CH_NUM*IN_W-1:0]     ch_data,
  input  logic                       vol_we,
  input  logic [$clog2(CH_NUM)-1:0]  vol_addr,
  input  logic [2*VOL_W-1:0]         vol_wdata,
  output logic                       busy,
  output logic [OUT_W-1:0]           out_l,
  output logic [OUT_W-1:0]           out_r,
  output logic                       out_valid,
  output logic                       clip_l,
  output logic                       clip_r,
  output logic                       overrun
`ifdef AUDIO_MIXER_DSM_EN
  ,
  output logic                       dac_l,
  output logic                       dac_r
`endif
);

  localparam int AW     = $clog2(CH_NUM);
  localparam int PROD_W = IN_W + VOL_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(CH_NUM);
  localparam logic [AW-1:0] LAST_CH = AW'(CH_NUM - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t state_q, state_d;
  logic [AW-1:0] chIdx_q, chIdx_d;
  logic scaleStep_q, scaleStep_d;
  logic busy_q, busy_d;
  logic valid_q, valid_d;
  logic overrun_q, overrun_d;
  logic start, loadOut;

  logic signed [IN_W-1:0]   snap_q [CH_NUM];
  logic        [VOL_W-1:0]  volL_q [CH_NUM];
  logic        [VOL_W-1:0]  volR_q [CH_NUM];
  logic signed [PROD_W-1:0] prodL_q, prodR_q, prodL, prodR;
  logic signed [ACC_W-1:0]  accL_q, accR_q, shiftL, shiftR;
  logic [OUT_W-1:0] outL_q, outR_q, satL, satR;
  logic clipL_q, clipR_q, clipL, clipR;

  // SCALE takes two cycles: the first drains the registered product of the last channel,
  // the second shifts, saturates and publishes.
  always_comb begin
    state_d     = state_q;
    chIdx_d     = chIdx_q;
    scaleStep_d = 1'b0;
    valid_d     = 1'b0;
    overrun_d   = 1'b0;
    start       = 1'b0;
    loadOut     = 1'b0;
    case (state_q)
      IDLE: begin
        if (smp_strobe) begin
          start   = 1'b1;
          chIdx_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        overrun_d = smp_strobe;
        chIdx_d   = chIdx_q + 1'b1;
        if (chIdx_q == LAST_CH) state_d = SCALE;
      end
      SCALE: begin
        overrun_d   = smp_strobe;
        scaleStep_d = ~scaleStep_q;
        if (scaleStep_q) begin
          loadOut = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk21m) begin
    if (reset) begin
      state_q     <= IDLE;
      chIdx_q     <= '0;
      scaleStep_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chIdx_q     <= chIdx_d;
      scaleStep_q <= scaleStep_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Volumes are unsigned gains, so a zero MSB is prepended before the signed multiply.
  assign prodL = PROD_W'(snap_q[chIdx_q]) * PROD_W'($signed({1'b0, volL_q[chIdx_q]}));
  assign prodR = PROD_W'(snap_q[chIdx_q]) * PROD_W'($signed({1'b0, volR_q[chIdx_q]}));

  assign shiftL = accL_q >>> VOL_W;
  assign shiftR = accR_q >>> VOL_W;
  assign clipL  = (shiftL > SAT_MAX) || (shiftL < SAT_MIN);
  assign clipR  = (shiftR > SAT_MAX) || (shiftR < SAT_MIN);
  assign satL   = clipL ? (shiftL[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                        : shiftL[OUT_W-1:0];
  assign satR   = clipR ? (shiftR[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                        : shiftR[OUT_W-1:0];

  always_ff @(posedge clk21m) begin
    if (reset) begin
      for (int k = 0; k < CH_NUM; k++) begin
        snap_q[k] <= '0;
        volL_q[k] <= '0;
        volR_q[k] <= '0;
      end
      prodL_q <= '0;
      prodR_q <= '0;
      accL_q  <= '0;
      accR_q  <= '0;
      outL_q  <= '0;
      outR_q  <= '0;
      clipL_q <= 1'b0;
      clipR_q <= 1'b0;
    end else begin
      if (start) begin
        for (int k = 0; k < CH_NUM; k++) snap_q[k] <= ch_data[k*IN_W +: IN_W];
        prodL_q <= '0;
        prodR_q <= '0;
        accL_q  <= '0;
        accR_q  <= '0;
      end else if (state_q == ACCUM) begin
        prodL_q <= prodL;
        prodR_q <= prodR;
        accL_q  <= accL_q + ACC_W'(prodL_q);
        accR_q  <= accR_q + ACC_W'(prodR_q);
      end else if (state_q == SCALE && !scaleStep_q) begin
        accL_q  <= accL_q + ACC_W'(prodL_q);
        accR_q  <= accR_q + ACC_W'(prodR_q);
      end
      if (loadOut) begin
        outL_q  <= satL;
        outR_q  <= satR;
        clipL_q <= clipL;
        clipR_q <= clipR;
      end
      for (int k = 0; k < CH_NUM; k++) begin
        if (vol_we && vol_addr == AW'(k)) begin
          volL_q[k] <= vol_wdata[2*VOL_W-1:VOL_W];
          volR_q[k] <= vol_wdata[VOL_W-1:0];
        end
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign out_l     = outL_q;
  assign out_r     = outR_q;
  assign clip_l    = clipL_q;
  assign clip_r    = clipR_q;

`ifdef AUDIO_MIXER_DSM_EN
  // Offset-binary input into an OUT_W-bit accumulator; the carry is the 1-bit DAC stream.
  logic [OUT_W-1:0] dsmL_q, dsmR_q;
  logic dacL_q, dacR_q;
  logic [OUT_W:0] sumL, sumR;

  assign sumL = {1'b0, dsmL_q} + {1'b0, ~outL_q[OUT_W-1], outL_q[OUT_W-2:0]};
  assign sumR = {1'b0, dsmR_q} + {1'b0, ~outR_q[OUT_W-1], outR_q[OUT_W-2:0]};

  always_ff @(posedge clk21m) begin
    if (reset) begin
      dsmL_q <= '0;
      dsmR_q <= '0;
      dacL_q <= 1'b0;
      dacR_q <= 1'b0;
    end else begin
      dsmL_q <= sumL[OUT_W-1:0];
      dsmR_q <= sumR[OUT_W-1:0];
      dacL_q <= sumL[OUT_W];
      dacR_q <= sumR[OUT_W];
    end
  end

  assign dac_l = dacL_q;
  assign dac_r = dacR_q;
`endif

endmodule

// File: tb/tb_audio_mixer_tdm.sv
// Directed self-checking bench for audio_mixer_tdm (default parameters, 8 channels x 16 bits).
module tb_audio_mixer_tdm;

  localparam int CH = 8;
  localparam int IW = 16;

  logic clk21m = 1'b0;
  logic reset, smp_strobe, vol_we;
  logic [CH*IW-1:0] ch_data;
  logic [2:0] vol_addr;
  logic [7:0] vol_wdata;
  logic busy, out_valid, clip_l, clip_r, overrun;
  logic [15:0] out_l, out_r;
`ifdef AUDIO_MIXER_DSM_EN
  logic dac_l, dac_r;
`endif

  int nCompared = 0;
  int nMismatched = 0;

  audio_mixer_tdm dut (
    .clk21m(clk21m), .reset(reset), .smp_strobe(smp_strobe), .ch_data(ch_data),
    .vol_we(vol_we), .vol_addr(vol_addr), .vol_wdata(vol_wdata), .busy(busy),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .clip_l(clip_l),
    .clip_r(clip_r), .overrun(overrun)
`ifdef AUDIO_MIXER_DSM_EN
    , .dac_l(dac_l), .dac_r(dac_r)
`endif
  );

  always #5 clk21m = ~clk21m;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic stepCycle();
    @(posedge clk21m);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic writeVol(input int ch, input logic [3:0] vl, input logic [3:0] vr);
    vol_we    = 1'b1;
    vol_addr  = 3'(ch);
    vol_wdata = {vl, vr};
    stepCycle();
    vol_we    = 1'b0;
  endtask

  // Pulses the strobe with the given data and waits (bounded) for out_valid.
  task automatic applyStimulus(input logic [CH*IW-1:0] data, output int latency);
    ch_data    = data;
    smp_strobe = 1'b1;
    stepCycle();
    smp_strobe = 1'b0;
    checkOutput("overrun_on_accept", int'(overrun), 0);
    checkOutput("busy_after_strobe", int'(busy), 1);
    latency = 0;
    while (!out_valid && latency < 40) begin
      stepCycle();
      latency++;
    end
  endtask

  task automatic checkMix(input string tag, input int lat, input int expL, input int expR,
                          input int expClipL, input int expClipR);
    checkOutput({tag, "_latency"}, lat, 10);
    checkOutput({tag, "_out_l"}, int'($signed(out_l)), expL);
    checkOutput({tag, "_out_r"}, int'($signed(out_r)), expR);
    checkOutput({tag, "_clip_l"}, int'(clip_l), expClipL);
    checkOutput({tag, "_clip_r"}, int'(clip_r), expClipR);
    checkOutput({tag, "_busy_low"}, int'(busy), 0);
  endtask

`ifdef AUDIO_MIXER_DSM_EN
  task automatic countDacOnes(output int ones);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      stepCycle();
      ones += int'(dac_l);
    end
  endtask
`endif

  initial begin
    int lat, pulses, ones;
    logic [CH*IW-1:0] mixData;

    reset = 1'b1; smp_strobe = 1'b0; vol_we = 1'b0; vol_addr = '0; vol_wdata = '0;
    ch_data = '0;
    repeat (3) stepCycle();
    reset = 1'b0;

    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_overrun", int'(overrun), 0);
    checkOutput("reset_out_l", int'(out_l), 0);
    checkOutput("reset_out_r", int'(out_r), 0);
    checkOutput("reset_clips", int'({clip_l, clip_r}), 0);

`ifdef AUDIO_MIXER_DSM_EN
    countDacOnes(ones);
    checkOutput("dsm_zero_half_density", int'(ones >= 127 && ones <= 129), 1);
`endif

    // Volumes muted after reset: any data mixes to silence.
    applyStimulus({CH{16'h1000}}, lat);
    checkMix("muted", lat, 0, 0, 0, 0);

    writeVol(0, 4'd15, 4'd0);
    mixData = '0;
    mixData[15:0] = 16'd16384;
    applyStimulus(mixData, lat);
    checkMix("ch0_left", lat, 15360, 0, 0, 0);

    // Restart in the out_valid cycle itself; floor of negative result.
    mixData[15:0] = 16'hC000;
    applyStimulus(mixData, lat);
    checkMix("ch0_neg_back_to_back", lat, -15360, 0, 0, 0);

    for (int k = 0; k < CH; k++) writeVol(k, 4'd15, 4'd15);
    applyStimulus({CH{16'h7FFF}}, lat);
    checkMix("sat_pos", lat, 32767, 32767, 1, 1);

`ifdef AUDIO_MIXER_DSM_EN
    countDacOnes(ones);
    checkOutput("dsm_full_scale_density", int'(ones >= 255), 1);
`endif

    applyStimulus({CH{16'h8000}}, lat);
    checkMix("sat_neg", lat, -32768, -32768, 1, 1);

    // L = (1000*8 - 3000*2)>>4 = 125 ; R = (1000*4 - 3000*15)>>4 = floor(-2562.5) = -2563
    writeVol(0, 4'd8, 4'd4);
    writeVol(1, 4'd2, 4'd15);
    for (int k = 2; k < CH; k++) writeVol(k, 4'd0, 4'd0);
    mixData = {CH{16'd5000}};
    mixData[15:0]  = 16'd1000;
    mixData[31:16] = 16'hF448;
    applyStimulus(mixData, lat);
    checkMix("mixed", lat, 125, -2563, 0, 0);

    // Strobe dropped mid-mix; data changed after the snapshot must not matter.
    ch_data    = mixData;
    smp_strobe = 1'b1;
    stepCycle();
    smp_strobe = 1'b0;
    ch_data    = {CH{16'd7777}};
    repeat (3) stepCycle();
    smp_strobe = 1'b1;
    stepCycle();
    smp_strobe = 1'b0;
    checkOutput("overrun_pulse", int'(overrun), 1);
    checkOutput("overrun_busy", int'(busy), 1);
    stepCycle();
    checkOutput("overrun_one_cycle", int'(overrun), 0);
    lat = 5;
    while (!out_valid && lat < 40) begin
      stepCycle();
      lat++;
    end
    checkMix("overrun_mix", lat, 125, -2563, 0, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      stepCycle();
      pulses += int'(out_valid);
    end
    checkOutput("single_valid_pulse", pulses, 0);
    checkOutput("out_l_hold", int'($signed(out_l)), 125);

    // Reset in the middle of a mix aborts it and clears outputs.
    ch_data    = mixData;
    smp_strobe = 1'b1;
    stepCycle();
    smp_strobe = 1'b0;
    repeat (4) stepCycle();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(out_valid), 0);
    checkOutput("abort_out_l", int'(out_l), 0);
    checkOutput("abort_out_r", int'(out_r), 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      stepCycle();
      pulses += int'(out_valid);
    end
    checkOutput("abort_no_valid", pulses, 0);

    writeVol(0, 4'd15, 4'd0);
    mixData = '0;
    mixData[15:0] = 16'd16384;
    applyStimulus(mixData, lat);
    checkMix("after_abort", lat, 15360, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
